// File: rtl/blink_monitor.sv
// blink_monitor: downstream checker for the LED blinker stage.
// Verifies the flg period, flg pulse width and the led toggle lag, and
// reports lock status, a sticky error with cause code, the last measured
// interval and a saturating good-period count.
// Optional feature macro: BLINK_MONITOR_IRQ_EN adds irq (1-cycle pulse on
// ERR entry) and err_total (saturating count of ERR entries since reset).
`timescale 1ns/1ps

module blink_monitor #(
    parameter int unsigned     CBITS  = 32,
    parameter longint unsigned PERIOD = 64'd1 << CBITS,
    parameter int unsigned     LAG    = 1,
    parameter int unsigned     LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flg,
    input  logic             led,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CBITS:0]   last_interval,
    output logic [15:0]      good_cnt
`ifdef BLINK_MONITOR_IRQ_EN
    ,
    output logic             irq,
    output logic [7:0]       err_total
`endif
);

    localparam int unsigned   IW       = CBITS + 1;
    localparam int unsigned   GW       = 16;
    localparam logic [IW-1:0] P_W      = IW'(PERIOD);
    localparam logic [GW-1:0] LOCK_W   = GW'(LOCK_N);
    localparam logic [GW-1:0] GOOD_MAX = {GW{1'b1}};

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_SHORT = 3'd1;
    localparam logic [2:0] C_LONG  = 3'd2;
    localparam logic [2:0] C_WIDE  = 3'd3;
    localparam logic [2:0] C_STRAY = 3'd4;
    localparam logic [2:0] C_MISS  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_LOCK = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_flg_q;
    logic            r_led_q;
    logic [LAG-1:0]  r_lag;
    logic [IW-1:0]   r_ivl;

    logic            r_locked;
    logic            r_err;
    logic [2:0]      r_err_code;
    logic [IW-1:0]   r_last;
    logic [GW-1:0]   r_good;

    logic            w_locked_nxt;
    logic            w_err_nxt;
    logic [2:0]      w_err_code_nxt;
    logic [IW-1:0]   w_last_nxt;
    logic [GW-1:0]   w_good_nxt;
    logic            w_ivl_clr;
    logic            w_err_entry;

    logic            w_rise;
    logic            w_tog;
    logic            w_lag_hit;
    logic            w_short;
    logic            w_long;
    logic            w_wide;
    logic            w_stray;
    logic            w_miss;
    logic            w_good;
    logic [2:0]      w_cause;
    logic [GW-1:0]   w_good_inc;

    // Edge and toggle detection against the 1-cycle delayed input copies
    assign w_rise    = flg & ~r_flg_q;
    assign w_tog     = led ^ r_led_q;
    assign w_lag_hit = r_lag[LAG-1];

    // Raw fault conditions, evaluated against the interval count before update
    assign w_short = w_rise & (r_ivl < P_W);
    assign w_long  = (r_ivl == P_W) & ~w_rise;
    assign w_wide  = flg & r_flg_q;
    assign w_stray = w_tog & ~w_lag_hit;
    assign w_miss  = ~w_tog & w_lag_hit;
    assign w_good  = w_rise & (r_ivl == P_W);

    assign w_good_inc = (r_good == GOOD_MAX) ? r_good : r_good + GW'(1);

    // Fault priority encoder: lowest code wins when faults coincide
    always_comb begin
        w_cause = C_NONE;
        if (w_short) begin
            w_cause = C_SHORT;
        end else if (w_long) begin
            w_cause = C_LONG;
        end else if (w_wide) begin
            w_cause = C_WIDE;
        end else if (w_stray) begin
            w_cause = C_STRAY;
        end else if (w_miss) begin
            w_cause = C_MISS;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_locked_nxt   = r_locked;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;
        w_last_nxt     = r_last;
        w_good_nxt     = r_good;
        w_ivl_clr      = 1'b0;
        w_err_entry    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_locked_nxt = 1'b0;
                if (w_rise) begin
                    w_state_nxt = S_SYNC;
                end
            end

            S_SYNC, S_LOCK: begin
                if (w_cause != C_NONE) begin
                    w_state_nxt    = S_ERR;
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = w_cause;
                    w_locked_nxt   = 1'b0;
                    w_err_entry    = 1'b1;
                    if (w_short) begin
                        w_last_nxt = r_ivl;
                    end
                end else if (w_good) begin
                    w_last_nxt = r_ivl;
                    w_good_nxt = w_good_inc;
                    if ((r_state == S_SYNC) && (w_good_inc >= LOCK_W)) begin
                        w_state_nxt  = S_LOCK;
                        w_locked_nxt = 1'b1;
                    end
                end
            end

            S_ERR: begin
                w_locked_nxt = 1'b0;
                if (clr) begin
                    w_state_nxt    = S_IDLE;
                    w_err_nxt      = 1'b0;
                    w_err_code_nxt = C_NONE;
                    w_good_nxt     = '0;
                    w_ivl_clr      = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Input delay line, lag shift register and saturating interval counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flg_q <= 1'b0;
            r_led_q <= 1'b0;
            r_lag   <= '0;
            r_ivl   <= '0;
        end else begin
            r_flg_q <= flg;
            r_led_q <= led;
            r_lag   <= LAG'({r_lag, w_rise});
            if (w_ivl_clr) begin
                r_ivl <= '0;
            end else if (w_rise) begin
                r_ivl <= IW'(1);
            end else if (r_ivl != P_W) begin
                r_ivl <= r_ivl + IW'(1);
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= C_NONE;
            r_last     <= '0;
            r_good     <= '0;
        end else begin
            r_locked   <= w_locked_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_last     <= w_last_nxt;
            r_good     <= w_good_nxt;
        end
    end

    assign locked        = r_locked;
    assign err           = r_err;
    assign err_code      = r_err_code;
    assign last_interval = r_last;
    assign good_cnt      = r_good;

`ifdef BLINK_MONITOR_IRQ_EN
    logic       r_irq;
    logic [7:0] r_err_total;

    // ERR-entry pulse and saturating lifetime error count (survives clr)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq       <= 1'b0;
            r_err_total <= '0;
        end else begin
            r_irq <= w_err_entry;
            if (w_err_entry && (r_err_total != 8'hFF)) begin
                r_err_total <= r_err_total + 8'd1;
            end
        end
    end

    assign irq       = r_irq;
    assign err_total = r_err_total;
`else
    // Entry strobe only feeds the optional interrupt logic
    logic w_unused;
    assign w_unused = w_err_entry;
`endif

endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed-vector bench for blink_monitor with
// CBITS=4, PERIOD=16, LAG=1, LOCK_N=2. Expected values are hand-computed.
`timescale 1ns/1ps

module tb_blink_monitor;

    localparam int unsigned     CBITS  = 4;
    localparam longint unsigned PERIOD = 64'd16;
    localparam int unsigned     LAG    = 1;
    localparam int unsigned     LOCK_N = 2;

    logic           clk;
    logic           rst;
    logic           flg;
    logic           led;
    logic           clr;
    logic           locked;
    logic           err;
    logic [2:0]     err_code;
    logic [CBITS:0] last_interval;
    logic [15:0]    good_cnt;
`ifdef BLINK_MONITOR_IRQ_EN
    logic           irq;
    logic [7:0]     err_total;
`endif

    int unsigned n_vec;
    int unsigned n_miss;
    int unsigned exp_total;
    logic        led_v;

    blink_monitor #(
        .CBITS  (CBITS),
        .PERIOD (PERIOD),
        .LAG    (LAG),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flg           (flg),
        .led           (led),
        .clr           (clr),
        .locked        (locked),
        .err           (err),
        .err_code      (err_code),
        .last_interval (last_interval),
        .good_cnt      (good_cnt)
`ifdef BLINK_MONITOR_IRQ_EN
        ,
        .irq           (irq),
        .err_total     (err_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports miscompares
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: optionally toggle led, apply inputs, sample #1 after the edge
    task automatic cyc(input logic f, input logic t, input logic c);
        if (t) led_v = ~led_v;
        flg = f;
        led = led_v;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic rise_cyc();
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    // Lagged led toggle then quiet cycles; the next rise lands gap cycles after the last
    task automatic tail(input int gap);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (gap - 2) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_out(input string tag, input logic lk, input logic e,
                           input logic [2:0] code, input logic [CBITS:0] last,
                           input logic [15:0] good, input logic irq_e);
        chk({tag, ".locked"},   32'(locked),        32'(lk));
        chk({tag, ".err"},      32'(err),           32'(e));
        chk({tag, ".err_code"}, 32'(err_code),      32'(code));
        chk({tag, ".last_ivl"}, 32'(last_interval), 32'(last));
        chk({tag, ".good_cnt"}, 32'(good_cnt),      32'(good));
        if (irq_e) exp_total++;
`ifdef BLINK_MONITOR_IRQ_EN
        chk({tag, ".irq"},       32'(irq),       32'(irq_e));
        chk({tag, ".err_total"}, 32'(err_total), exp_total);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        exp_total = 0;
        led_v     = 1'b0;
        rst       = 1'b0;
        flg       = 1'b0;
        led       = 1'b0;
        clr       = 1'b0;

        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_out("reset", 1'b0, 1'b0, 3'd0, 5'd0, 16'd0, 1'b0);
        rst = 1'b1;

        // led toggles in IDLE are ignored
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk_out("idle_led", 1'b0, 1'b0, 3'd0, 5'd0, 16'd0, 1'b0);

        // Nominal lock-in
        rise_cyc();
        chk_out("rise1", 1'b0, 1'b0, 3'd0, 5'd0, 16'd0, 1'b0);
        tail(16);
        rise_cyc();
        chk_out("rise2", 1'b0, 1'b0, 3'd0, 5'd16, 16'd1, 1'b0);
        tail(16);
        rise_cyc();
        chk_out("rise3_lock", 1'b1, 1'b0, 3'd0, 5'd16, 16'd2, 1'b0);
        tail(16);
        rise_cyc();
        chk_out("rise4", 1'b1, 1'b0, 3'd0, 5'd16, 16'd3, 1'b0);

        // Short interval after lock
        tail(12);
        rise_cyc();
        chk_out("short", 1'b0, 1'b1, 3'd1, 5'd12, 16'd3, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        chk_out("err_hold", 1'b0, 1'b1, 3'd1, 5'd12, 16'd3, 1'b0);

        // clr coincident with a flg rise: rise is ignored, IDLE waits for the next one
        cyc(1'b1, 1'b0, 1'b1);
        chk_out("clr1", 1'b0, 1'b0, 3'd0, 5'd12, 16'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (7) cyc(1'b0, 1'b0, 1'b0);
        rise_cyc();
        chk_out("clr_rise_ignored", 1'b0, 1'b0, 3'd0, 5'd12, 16'd0, 1'b0);
        tail(16);
        rise_cyc();
        chk_out("relock_a", 1'b0, 1'b0, 3'd0, 5'd16, 16'd1, 1'b0);
        tail(16);
        rise_cyc();
        chk_out("relock_b", 1'b1, 1'b0, 3'd0, 5'd16, 16'd2, 1'b0);

        // Missing flg; clr while locked has no effect
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (13) cyc(1'b0, 1'b0, 1'b0);
        chk_out("pre_long", 1'b1, 1'b0, 3'd0, 5'd16, 16'd2, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_out("long", 1'b0, 1'b1, 3'd2, 5'd16, 16'd2, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk_out("clr2", 1'b0, 1'b0, 3'd0, 5'd16, 16'd0, 1'b0);

        // Wide flg right after entering SYNC
        rise_cyc();
        cyc(1'b1, 1'b1, 1'b0);
        chk_out("wide", 1'b0, 1'b1, 3'd3, 5'd16, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk_out("clr3", 1'b0, 1'b0, 3'd0, 5'd16, 16'd0, 1'b0);

        // Short flg coinciding with a stray toggle: short wins
        rise_cyc();
        cyc(1'b0, 1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk_out("short_stray", 1'b0, 1'b1, 3'd1, 5'd8, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Stray led toggle mid-period
        rise_cyc();
        cyc(1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        chk_out("pre_stray", 1'b0, 1'b0, 3'd0, 5'd8, 16'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk_out("stray", 1'b0, 1'b1, 3'd4, 5'd8, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Missing led toggle one cycle after flg
        rise_cyc();
        cyc(1'b0, 1'b0, 1'b0);
        chk_out("missing", 1'b0, 1'b1, 3'd5, 5'd8, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk_out("clr4", 1'b0, 1'b0, 3'd0, 5'd8, 16'd0, 1'b0);

        // Reset in LOCK, then relock
        rise_cyc();
        tail(16);
        rise_cyc();
        tail(16);
        rise_cyc();
        chk_out("lock_c", 1'b1, 1'b0, 3'd0, 5'd16, 16'd2, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        exp_total = 0;
        chk_out("mid_reset", 1'b0, 1'b0, 3'd0, 5'd0, 16'd0, 1'b0);
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        rise_cyc();
        chk_out("post_rst_r1", 1'b0, 1'b0, 3'd0, 5'd0, 16'd0, 1'b0);
        tail(16);
        rise_cyc();
        chk_out("post_rst_r2", 1'b0, 1'b0, 3'd0, 5'd16, 16'd1, 1'b0);
        tail(16);
        rise_cyc();
        chk_out("post_rst_lock", 1'b1, 1'b0, 3'd0, 5'd16, 16'd2, 1'b0);
        tail(16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
